// File: rtl/sd_cmd_engine_if.sv
// Command and byte-level SPI bundle for sd_cmd_engine.
// slave is the engine's view; master is the sequencer/SPI side.
interface sd_cmd_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic [2:0]  resp_len;
  logic        resp_busy;
  logic        done;
  logic [7:0]  r1;
  logic [31:0] resp_data;
  logic        timeout;
  logic        cs;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_done;
  logic [7:0]  spi_rx;

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, resp_len, resp_busy, spi_done, spi_rx,
    output cmd_ready, done, r1, resp_data, timeout, cs, spi_start, spi_tx
  );

  modport master (
    output cmd_valid, cmd_index, cmd_arg, resp_len, resp_busy, spi_done, spi_rx,
    input  cmd_ready, done, r1, resp_data, timeout, cs, spi_start, spi_tx
  );
endinterface

// File: rtl/sd_cmd_engine.sv
// SD SPI-mode command engine: frames a 48-bit command with CRC7, polls R1,
// collects extra response bytes, waits out R1b busy, then clocks trailing bytes.
module sd_cmd_engine #(
  parameter int NCR_MAX     = 8,
  parameter int BUSY_MAX    = 65535,
  parameter int TRAIL_BYTES = 1
) (
  input  logic           clk,
  input  logic           rst,
  sd_cmd_engine_if.slave bus
);

  localparam int M1   = (NCR_MAX > 6) ? NCR_MAX : 6;
  localparam int M2   = (BUSY_MAX > M1) ? BUSY_MAX : M1;
  localparam int CMAX = (TRAIL_BYTES > M2) ? TRAIL_BYTES : M2;
  localparam int CW   = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t NCR_LIM   = cnt_t'(NCR_MAX);
  localparam cnt_t BUSY_LIM  = cnt_t'(BUSY_MAX);
  localparam cnt_t TRAIL_LIM = cnt_t'(TRAIL_BYTES);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    POLL_R1,
    RX_EXTRA,
    BUSY_WAIT,
    TRAIL,
    DONE
  } state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        start_q, start_d;
  logic [7:0]  tx_q, tx_d;
  logic        cs_q, cs_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [2:0]  len_q, len_d;
  logic        busy_q, busy_d;
  logic [7:0]  r1_q, r1_d;
  logic [31:0] resp_q, resp_d;
  logic        timeout_q, timeout_d;

  cnt_t        cnt_inc;
  logic        byte_done;
  logic [6:0]  crc_w;
  logic [7:0]  frame_byte;

  function automatic logic [6:0] crc7(input logic [39:0] data);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CRC comes purely from latched fields, so it is stable long before byte 5 is sent.
  assign crc_w     = crc7({2'b01, idx_q, arg_q});
  assign cnt_inc   = cnt_q + cnt_t'(1);
  assign byte_done = pend_q && bus.spi_done;

  always_comb begin
    frame_byte = {crc_w, 1'b1};
    case (cnt_inc)
      cnt_t'(1): frame_byte = arg_q[31:24];
      cnt_t'(2): frame_byte = arg_q[23:16];
      cnt_t'(3): frame_byte = arg_q[15:8];
      cnt_t'(4): frame_byte = arg_q[7:0];
      default:   frame_byte = {crc_w, 1'b1};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    start_d   = 1'b0;
    tx_d      = tx_q;
    cs_d      = cs_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    len_d     = len_q;
    busy_d    = busy_q;
    r1_d      = r1_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;

    if (byte_done) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          idx_d     = bus.cmd_index;
          arg_d     = bus.cmd_arg;
          len_d     = (bus.resp_len > 3'd4) ? 3'd4 : bus.resp_len;
          busy_d    = bus.resp_busy;
          timeout_d = 1'b0;
          resp_d    = '0;
          r1_d      = 8'hFF;
          cnt_d     = '0;
          cs_d      = 1'b0;
          start_d   = 1'b1;
          pend_d    = 1'b1;
          tx_d      = {2'b01, bus.cmd_index};
          state_d   = SEND;
        end
      end

      SEND: begin
        if (byte_done) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
          if (cnt_q == cnt_t'(5)) begin
            cnt_d   = '0;
            tx_d    = 8'hFF;
            state_d = POLL_R1;
          end else begin
            cnt_d = cnt_inc;
            tx_d  = frame_byte;
          end
        end
      end

      POLL_R1: begin
        if (byte_done) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
          tx_d    = 8'hFF;
          if (!bus.spi_rx[7]) begin
            r1_d  = bus.spi_rx;
            cnt_d = '0;
            if (len_q != 3'd0)  state_d = RX_EXTRA;
            else if (busy_q)    state_d = BUSY_WAIT;
            else                state_d = TRAIL;
          end else if (cnt_inc == NCR_LIM) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = TRAIL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      RX_EXTRA: begin
        if (byte_done) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
          tx_d    = 8'hFF;
          resp_d  = {resp_q[23:0], bus.spi_rx};
          if (cnt_inc == cnt_t'(len_q)) begin
            cnt_d   = '0;
            state_d = busy_q ? BUSY_WAIT : TRAIL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      BUSY_WAIT: begin
        if (byte_done) begin
          start_d = 1'b1;
          pend_d  = 1'b1;
          tx_d    = 8'hFF;
          if (bus.spi_rx == 8'hFF) begin
            cnt_d   = '0;
            state_d = TRAIL;
          end else if (cnt_inc == BUSY_LIM) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = TRAIL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      TRAIL: begin
        if (byte_done) begin
          if (cnt_inc == TRAIL_LIM) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_inc;
            start_d = 1'b1;
            pend_d  = 1'b1;
            tx_d    = 8'hFF;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Chip select is released together with the first trailing byte's start.
    if (state_d == TRAIL && state_q != TRAIL) cs_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      tx_q      <= 8'hFF;
      cs_q      <= 1'b1;
      idx_q     <= '0;
      arg_q     <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      r1_q      <= 8'hFF;
      resp_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      tx_q      <= tx_d;
      cs_q      <= cs_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      r1_q      <= r1_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.r1        = r1_q;
  assign bus.resp_data = resp_q;
  assign bus.timeout   = timeout_q;
  assign bus.cs        = cs_q;
  assign bus.spi_start = start_q;
  assign bus.spi_tx    = tx_q;

endmodule
